// File: rtl/hex_display_bank.sv
// N-digit hex 7-segment driver: per-digit value/blank/blink registers, static parallel
// outputs and a time-multiplexed scan bus with a free-running blink phase.
module hex_display_bank #(
  parameter int  NUM_DIGITS     = 4,
  parameter int  SCAN_DIV       = 50000,
  parameter int  BLINK_DIV      = 25000000,
  parameter bit  ACTIVE_LOW_SEG = 1'b1,
  localparam int SEL_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [SEL_W-1:0]        wr_sel,
  input  logic [3:0]              value_in,
  input  logic                    blank_in,
  input  logic                    blink_in,
  input  logic                    clear,
  output logic [7*NUM_DIGITS-1:0] displays,
  output logic [6:0]              scan_seg,
  output logic [NUM_DIGITS-1:0]   scan_en,
  output logic                    blink_phase
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [SEL_W-1:0]   IDX_LAST   = SEL_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][3:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]      blank_q, blank_d;
  logic [NUM_DIGITS-1:0]      blink_q, blink_d;

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [SEL_W-1:0]   scan_idx_q, scan_idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  logic [NUM_DIGITS-1:0][6:0] digit_seg;

  // Active-high gfedcba pattern; polarity is applied afterwards.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
    val_d   = val_q;
    blank_d = blank_q;
    blink_d = blink_q;
    if (clear) begin
      val_d   = '0;
      blank_d = '1;
      blink_d = '0;
    end else if (wr_en && (int'(wr_sel) < NUM_DIGITS)) begin
      val_d[wr_sel]   = value_in;
      blank_d[wr_sel] = blank_in;
      blink_d[wr_sel] = blink_in;
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + SEL_W'(1);
    end

    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: the digit registers are a handful of flops, not a RAM, so they are reset to a known dark state.
      val_q         <= '0;
      blank_q       <= '1;
      blink_q       <= '0;
      scan_cnt_q    <= '0;
      scan_idx_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      val_q         <= val_d;
      blank_q       <= blank_d;
      blink_q       <= blink_d;
      scan_cnt_q    <= scan_cnt_d;
      scan_idx_q    <= scan_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_seg[i] = (blank_q[i] || (blink_q[i] && blink_phase_q)) ? 7'h00 : hex_to_seg(val_q[i]);
      if (ACTIVE_LOW_SEG) digit_seg[i] = ~digit_seg[i];
    end
  end

  // Packed layout already places digit i on bits [7i+6:7i].
  assign displays    = digit_seg;
  assign blink_phase = blink_phase_q;

  always_comb begin
    scan_seg = digit_seg[0];
    scan_en  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(scan_idx_q) == i) begin
        scan_seg   = digit_seg[i];
        scan_en[i] = 1'b1;
      end
    end
  end

endmodule
